// File: rtl/debug_controller.sv
// debug_controller: UART-driven debug command front end.
// Receives framed commands from a host, strobes each one to the target for a
// single cycle, then returns a status byte or read data over the same UART.
module debug_controller #(
  parameter int CLK_RATE = 50,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        srx,
  output logic        stx,
  output logic        pause,
  output logic        resume,
  output logic        reset,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        reg_rd,
  output logic        reg_wr,
  output logic        valid,
  output logic [31:0] addr,
  output logic [31:0] d_in,
  output logic [1:0]  mem_size,
  input  logic        mcu_busy,
  input  logic        error,
  input  logic [31:0] d_rd
);

  localparam int DIVISOR = (CLK_RATE * 1000000) / BAUD;
  localparam int CW      = $clog2(DIVISOR + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIVISOR / 2 - 1);

  localparam logic [2:0] OP_PAUSE  = 3'd1;
  localparam logic [2:0] OP_RESUME = 3'd2;
  localparam logic [2:0] OP_RESET  = 3'd3;
  localparam logic [2:0] OP_MEM_RD = 3'd4;
  localparam logic [2:0] OP_MEM_WR = 3'd5;
  localparam logic [2:0] OP_REG_RD = 3'd6;
  localparam logic [2:0] OP_REG_WR = 3'd7;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, GET_ARGS, ISSUE, WAIT, REPLY} state_t;

  // Number of argument bytes that follow each opcode.
  function automatic logic [3:0] arg_len(input logic [2:0] op);
    case (op)
      OP_MEM_RD: arg_len = 4'd5;
      OP_MEM_WR: arg_len = 4'd9;
      OP_REG_RD: arg_len = 4'd4;
      OP_REG_WR: arg_len = 4'd8;
      default:   arg_len = 4'd0;
    endcase
  endfunction

  logic          sync1_q, sync2_q, sync3_q;
  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_valid_q, rx_valid_d;

  logic          tx_busy_q, tx_busy_d;
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic          stx_q, stx_d;
  logic          tx_start;
  logic          tx_done;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [3:0]    arg_idx_q, arg_idx_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   d_in_q, d_in_d;
  logic [1:0]    mem_size_q, mem_size_d;
  logic [31:0]   reply_buf_q, reply_buf_d;
  logic [2:0]    reply_left_q, reply_left_d;
  logic          has_size;
  logic [3:0]    arg_pos;

  // Bring srx into the clock domain and keep one extra stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= srx;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Receiver: find the start edge, sample each bit at its mid-point, drop bad stop bits.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (sync3_q && !sync2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = 3'd0;
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_valid_d = sync2_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Transmitter: shift out start, 8 data bits LSB first, stop; pulse done at end of stop.
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    stx_d      = stx_q;
    tx_done    = 1'b0;
    if (!tx_busy_q) begin
      if (tx_start) begin
        tx_busy_d  = 1'b1;
        tx_shift_d = {1'b1, reply_buf_q[31:24], 1'b0};
        tx_cnt_d   = '0;
        tx_bit_d   = 4'd0;
        stx_d      = 1'b0;
      end
    end else if (tx_cnt_q == BIT_LAST) begin
      tx_cnt_d = '0;
      if (tx_bit_q == 4'd9) begin
        tx_busy_d = 1'b0;
        tx_done   = 1'b1;
        stx_d     = 1'b1;
      end else begin
        tx_bit_d   = tx_bit_q + 4'd1;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        stx_d      = tx_shift_q[1];
      end
    end else begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end
  end

  // Transmitter state register; the line idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q  <= 1'b0;
      tx_shift_q <= 10'h3FF;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 4'd0;
      stx_q      <= 1'b1;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      stx_q      <= stx_d;
    end
  end

  assign has_size = (op_q == OP_MEM_RD) || (op_q == OP_MEM_WR);
  assign arg_pos  = arg_idx_q - {3'b000, has_size};

  // Command FSM: collect the frame, strobe it, wait on the target, send the reply.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    arg_idx_d    = arg_idx_q;
    addr_d       = addr_q;
    d_in_d       = d_in_q;
    mem_size_d   = mem_size_q;
    reply_buf_d  = reply_buf_q;
    reply_left_d = reply_left_q;
    tx_start     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid_q) begin
          if (rx_shift_q >= 8'h01 && rx_shift_q <= 8'h07) begin
            op_d      = rx_shift_q[2:0];
            arg_idx_d = 4'd0;
            state_d   = (arg_len(rx_shift_q[2:0]) == 4'd0) ? ISSUE : GET_ARGS;
          end else begin
            reply_buf_d  = {8'hEE, 24'h000000};
            reply_left_d = 3'd1;
            state_d      = REPLY;
          end
        end
      end
      GET_ARGS: begin
        if (rx_valid_q) begin
          if (has_size && arg_idx_q == 4'd0) begin
            mem_size_d = rx_shift_q[1:0];
          end else if (arg_pos < 4'd4) begin
            addr_d = {addr_q[23:0], rx_shift_q};
          end else begin
            d_in_d = {d_in_q[23:0], rx_shift_q};
          end
          if (arg_idx_q == arg_len(op_q) - 4'd1) begin
            state_d = ISSUE;
          end else begin
            arg_idx_d = arg_idx_q + 4'd1;
          end
        end
      end
      ISSUE: begin
        if (error) begin
          reply_buf_d  = {8'hEE, 24'h000000};
          reply_left_d = 3'd1;
          state_d      = REPLY;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!mcu_busy) begin
          if (op_q == OP_MEM_RD || op_q == OP_REG_RD) begin
            reply_buf_d  = d_rd;
            reply_left_d = 3'd4;
          end else begin
            reply_buf_d  = {8'hAA, 24'h000000};
            reply_left_d = 3'd1;
          end
          state_d = REPLY;
        end
      end
      REPLY: begin
        if (!tx_busy_q && reply_left_q != 3'd0) begin
          tx_start     = 1'b1;
          reply_buf_d  = {reply_buf_q[23:0], 8'h00};
          reply_left_d = reply_left_q - 3'd1;
        end
        if (tx_done && reply_left_q == 3'd0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command FSM state and field registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= 3'd0;
      arg_idx_q    <= 4'd0;
      addr_q       <= 32'h0;
      d_in_q       <= 32'h0;
      mem_size_q   <= 2'd0;
      reply_buf_q  <= 32'h0;
      reply_left_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      arg_idx_q    <= arg_idx_d;
      addr_q       <= addr_d;
      d_in_q       <= d_in_d;
      mem_size_q   <= mem_size_d;
      reply_buf_q  <= reply_buf_d;
      reply_left_q <= reply_left_d;
    end
  end

  assign valid    = (state_q == ISSUE);
  assign pause    = valid && (op_q == OP_PAUSE);
  assign resume   = valid && (op_q == OP_RESUME);
  assign reset    = valid && (op_q == OP_RESET);
  assign mem_rd   = valid && (op_q == OP_MEM_RD);
  assign mem_wr   = valid && (op_q == OP_MEM_WR);
  assign reg_rd   = valid && (op_q == OP_REG_RD);
  assign reg_wr   = valid && (op_q == OP_REG_WR);
  assign addr     = addr_q;
  assign d_in     = d_in_q;
  assign mem_size = mem_size_q;
  assign stx      = stx_q;

endmodule

// File: tb/tb_debug_controller.sv
// tb_debug_controller: scoreboard bench for debug_controller.
// Stimulus pushes expected commands and reply bytes; monitors pop and compare.
module tb_debug_controller;

  localparam int CLK_RATE = 4;
  localparam int BAUD     = 250000;
  localparam int DIV      = (CLK_RATE * 1000000) / BAUD;
  localparam int BUDGET   = 60 * DIV;

  localparam logic [6:0] F_PAUSE  = 7'b1000000;
  localparam logic [6:0] F_RESUME = 7'b0100000;
  localparam logic [6:0] F_MEM_RD = 7'b0001000;
  localparam logic [6:0] F_MEM_WR = 7'b0000100;
  localparam logic [6:0] F_REG_RD = 7'b0000010;

  typedef struct packed {
    logic [6:0]  flags;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic [1:0]  mem_size;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        srx = 1'b1;
  logic        stx;
  logic        pause, resume, reset_flag, mem_rd, mem_wr, reg_rd, reg_wr;
  logic        valid;
  logic [31:0] addr, d_in;
  logic [1:0]  mem_size;
  logic        mcu_busy = 1'b0;
  logic        error = 1'b0;
  logic [31:0] d_rd = 32'h0;
  logic [6:0]  act_flags;

  cmd_t        exp_cmd_q[$];
  logic [7:0]  exp_byte_q[$];
  logic [7:0]  stim_q[$];
  int          check_count = 0;
  int          error_count = 0;
  int          resp_busy = 0;
  logic        resp_error = 1'b0;
  logic [31:0] resp_rd = 32'h0;

  assign act_flags = {pause, resume, reset_flag, mem_rd, mem_wr, reg_rd, reg_wr};

  debug_controller #(.CLK_RATE(CLK_RATE), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .srx(srx), .stx(stx),
    .pause(pause), .resume(resume), .reset(reset_flag),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_rd(reg_rd), .reg_wr(reg_wr),
    .valid(valid), .addr(addr), .d_in(d_in), .mem_size(mem_size),
    .mcu_busy(mcu_busy), .error(error), .d_rd(d_rd)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic expectCmd(input logic [6:0] flags, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    cmd_t c;
    c.flags    = flags;
    c.addr     = a;
    c.d_in     = d;
    c.mem_size = sz;
    exp_cmd_q.push_back(c);
  endtask

  task automatic sendByte(input logic [7:0] b);
    srx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      srx = b[i];
      repeat (DIV) @(negedge clk);
    end
    srx = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    while (stim_q.size() > 0) sendByte(stim_q.pop_front());
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((exp_cmd_q.size() > 0 || exp_byte_q.size() > 0) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard_drain", exp_cmd_q.size() + exp_byte_q.size(), 0);
    exp_cmd_q.delete();
    exp_byte_q.delete();
    repeat (4 * DIV) @(negedge clk);
  endtask

  task automatic checkResetState();
    checkOutput("reset_stx", {31'h0, stx}, 32'h1);
    checkOutput("reset_valid", {31'h0, valid}, 32'h0);
    checkOutput("reset_flags", {25'h0, act_flags}, 32'h0);
    checkOutput("reset_addr", addr, 32'h0);
    checkOutput("reset_d_in", d_in, 32'h0);
    checkOutput("reset_mem_size", {30'h0, mem_size}, 32'h0);
  endtask

  // Command monitor: every valid pulse must match the next expected command and last one cycle.
  initial begin : cmd_monitor
    cmd_t e;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        if (exp_cmd_q.size() == 0) begin
          check_count++;
          error_count++;
          $display("[TB] FAIL unexpected_valid flags=%b required=no pulse", act_flags);
        end else begin
          e = exp_cmd_q.pop_front();
          checkOutput("cmd_flags", {25'h0, act_flags}, {25'h0, e.flags});
          checkOutput("cmd_addr", addr, e.addr);
          checkOutput("cmd_d_in", d_in, e.d_in);
          checkOutput("cmd_mem_size", {30'h0, mem_size}, {30'h0, e.mem_size});
          @(negedge clk);
          checkOutput("valid_one_cycle", {31'h0, valid}, 32'h0);
        end
      end
    end
  end

  // Reply monitor: decode each stx frame and compare with the next expected byte.
  initial begin : stx_monitor
    logic [7:0] rx;
    logic       stop_bit;
    forever begin
      @(negedge stx);
      repeat (DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        rx[i] = stx;
      end
      repeat (DIV) @(negedge clk);
      stop_bit = stx;
      if (exp_byte_q.size() == 0) begin
        check_count++;
        error_count++;
        $display("[TB] FAIL unexpected_reply actual=%0h required=none", rx);
      end else begin
        checkOutput("reply_byte", {24'h0, rx}, {24'h0, exp_byte_q.pop_front()});
        checkOutput("reply_stop_bit", {31'h0, stop_bit}, 32'h1);
      end
    end
  end

  // Target model: drives error in the valid cycle and an optional busy period with read data.
  initial begin : responder
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        error = resp_error;
        if (resp_busy > 0) begin
          mcu_busy = 1'b1;
          d_rd = 32'h0;
        end
        @(negedge clk);
        error = 1'b0;
        if (resp_busy > 0) begin
          repeat (resp_busy) @(negedge clk);
          mcu_busy = 1'b0;
          d_rd = resp_rd;
          @(negedge clk);
          d_rd = 32'h0BADF00D;
        end
      end
    end
  end

  // Watchdog against a hung run.
  initial begin : watchdog
    repeat (100000) @(negedge clk);
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin : main
    repeat (3) @(negedge clk);
    checkResetState();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] pause");
    expectCmd(F_PAUSE, 32'h0, 32'h0, 2'd0);
    exp_byte_q.push_back(8'hAA);
    stim_q = '{8'h01};
    applyStimulus();
    waitDrain();

    $display("[TB] reg_rd with busy target");
    resp_busy = 3;
    resp_rd   = 32'hDEADBEEF;
    expectCmd(F_REG_RD, 32'h5, 32'h0, 2'd0);
    exp_byte_q.push_back(8'hDE);
    exp_byte_q.push_back(8'hAD);
    exp_byte_q.push_back(8'hBE);
    exp_byte_q.push_back(8'hEF);
    stim_q = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h05};
    applyStimulus();
    waitDrain();
    resp_busy = 0;

    $display("[TB] mem_wr");
    expectCmd(F_MEM_WR, 32'h100, 32'h12345678, 2'd2);
    exp_byte_q.push_back(8'hAA);
    stim_q = '{8'h05, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
    applyStimulus();
    waitDrain();

    $display("[TB] mem_rd rejected while target busy");
    resp_error = 1'b1;
    mcu_busy   = 1'b1;
    expectCmd(F_MEM_RD, 32'h11000000, 32'h12345678, 2'd2);
    exp_byte_q.push_back(8'hEE);
    stim_q = '{8'h04, 8'h02, 8'h11, 8'h00, 8'h00, 8'h00};
    applyStimulus();
    waitDrain();
    resp_error = 1'b0;
    mcu_busy   = 1'b0;
    repeat (4 * DIV) @(negedge clk);

    $display("[TB] unknown opcode");
    exp_byte_q.push_back(8'hEE);
    stim_q = '{8'h09};
    applyStimulus();
    waitDrain();

    $display("[TB] reset mid-frame");
    stim_q = '{8'h06, 8'h00};
    applyStimulus();
    srx = 1'b0;
    repeat (DIV) @(negedge clk);
    srx = 1'b1;
    repeat (DIV) @(negedge clk);
    srx = 1'b0;
    repeat (DIV) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkResetState();
    srx = 1'b1;
    repeat (DIV) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    expectCmd(F_RESUME, 32'h0, 32'h0, 2'd0);
    exp_byte_q.push_back(8'hAA);
    stim_q = '{8'h02};
    applyStimulus();
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
